// File: rtl/max_scan_ctrl.sv
// Running-max sequencer for the 10-to-1 softmax input mux: steps sel 1..10,
// tracks the signed maximum and its position. Optional abort input: MAX_SCAN_ABORT_EN.
module max_scan_ctrl #(
  parameter int DATA_WIDTH = 24
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
`ifdef MAX_SCAN_ABORT_EN
  input  logic                  abort,
`endif
  input  logic [DATA_WIDTH-1:0] mux_out,
  output logic [3:0]            sel,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] max_val,
  output logic [3:0]            max_idx
);

  typedef enum logic {IDLE, SCAN} state_t;

  localparam logic [3:0] LAST_SEL = 4'd10;

  state_t                        state_q, state_d;
  logic [3:0]                    sel_q, sel_d;
  logic                          done_q, done_d;
  logic [DATA_WIDTH-1:0]         max_val_q, max_val_d;
  logic [3:0]                    max_idx_q, max_idx_d;
  logic signed [DATA_WIDTH-1:0]  run_max_q, run_max_d;
  logic [3:0]                    run_idx_q, run_idx_d;
  logic signed [DATA_WIDTH-1:0]  cand_max;
  logic [3:0]                    cand_idx;
  logic                          abort_w;

`ifdef MAX_SCAN_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  // The first element seeds the running max; later ones replace it only on a
  // strictly greater value, so ties keep the lowest position.
  always_comb begin
    cand_max = run_max_q;
    cand_idx = run_idx_q;
    if ((sel_q == 4'd1) || ($signed(mux_out) > run_max_q)) begin
      cand_max = $signed(mux_out);
      cand_idx = sel_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    done_d    = 1'b0;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    run_max_d = run_max_q;
    run_idx_d = run_idx_q;
    case (state_q)
      IDLE: begin
        if (start && !abort_w) begin
          state_d = SCAN;
          sel_d   = 4'd1;
        end
      end
      SCAN: begin
        if (abort_w) begin
          state_d = IDLE;
          sel_d   = 4'd0;
        end else begin
          run_max_d = cand_max;
          run_idx_d = cand_idx;
          if (sel_q == LAST_SEL) begin
            max_val_d = cand_max;
            max_idx_d = cand_idx;
            done_d    = 1'b1;
            sel_d     = 4'd0;
            state_d   = IDLE;
          end else begin
            sel_d = sel_q + 4'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= 4'd0;
      done_q    <= 1'b0;
      max_val_q <= '0;
      max_idx_q <= 4'd0;
      run_max_q <= '0;
      run_idx_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      done_q    <= done_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
      run_max_q <= run_max_d;
      run_idx_q <= run_idx_d;
    end
  end

  assign sel     = sel_q;
  assign busy    = (state_q == SCAN);
  assign done    = done_q;
  assign max_val = max_val_q;
  assign max_idx = max_idx_q;

endmodule

// File: tb/tb_max_scan_ctrl.sv
// Scoreboard bench for max_scan_ctrl: directed logit sets with hand-computed
// maxima; a negedge monitor pops the expected result on every done pulse.
module tb_max_scan_ctrl;

  localparam int DW = 24;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
`ifdef MAX_SCAN_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic [DW-1:0] mux_out;
  logic [3:0]    sel;
  logic          busy;
  logic          done;
  logic [DW-1:0] max_val;
  logic [3:0]    max_idx;

  logic signed [DW-1:0] logits [10];

  typedef struct packed {
    logic [DW-1:0] v;
    logic [3:0]    i;
  } exp_t;
  exp_t sb_q [$];

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] prev_val = '0;
  logic [3:0]    prev_idx = 4'd0;

  always #5 clk = ~clk;

  max_scan_ctrl #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
`ifdef MAX_SCAN_ABORT_EN
    .abort   (abort),
`endif
    .mux_out (mux_out),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .max_val (max_val),
    .max_idx (max_idx)
  );

  // Behavioural mux: sel 1..10 selects logits[0..9], 0 parks at zero.
  always_comb begin
    mux_out = '0;
    if (sel >= 4'd1 && sel <= 4'd10) mux_out = logits[int'(sel) - 1];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("sb_max_val", {8'd0, max_val}, {8'd0, e.v});
        chk("sb_max_idx", {28'd0, max_idx}, {28'd0, e.i});
        $display("done: max_val=%0h max_idx=%0d (expected %0h/%0d)", max_val, max_idx, e.v, e.i);
      end
    end
  end

  task automatic set_ramp(input bit ascending);
    for (int k = 0; k < 10; k++) logits[k] = ascending ? DW'(k + 1) : DW'(10 - k);
  endtask

  // Called 1ns after a posedge. cut_at: cycle index (sel value) whose edge
  // carries rst (kind 1) or abort (kind 2); 0 means run to completion.
  task automatic run_scan(input logic [DW-1:0] ev, input logic [3:0] ei,
                          input int repulse_at, input int cut_at, input int kind);
    if (cut_at == 0) sb_q.push_back({ev, ei});
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      chk("scan_sel", {28'd0, sel}, i);
      chk("scan_busy", {31'd0, busy}, 32'd1);
      chk("scan_no_done", {31'd0, done}, 32'd0);
      chk("scan_hold_val", {8'd0, max_val}, {8'd0, prev_val});
      chk("scan_hold_idx", {28'd0, max_idx}, {28'd0, prev_idx});
      start = (i == repulse_at);
      if (i == cut_at && kind == 1) rst = 1'b1;
`ifdef MAX_SCAN_ABORT_EN
      if (i == cut_at && kind == 2) abort = 1'b1;
`endif
      @(posedge clk); #1;
      start = 1'b0;
      if (i == cut_at) begin
        rst = 1'b0;
`ifdef MAX_SCAN_ABORT_EN
        abort = 1'b0;
`endif
        if (kind == 1) begin
          prev_val = '0;
          prev_idx = 4'd0;
        end
        chk("cut_sel", {28'd0, sel}, 32'd0);
        chk("cut_busy", {31'd0, busy}, 32'd0);
        chk("cut_no_done", {31'd0, done}, 32'd0);
        chk("cut_max_val", {8'd0, max_val}, {8'd0, prev_val});
        chk("cut_max_idx", {28'd0, max_idx}, {28'd0, prev_idx});
        $display("scan cut at sel=%0d kind=%0d: sel=%0d busy=%0b max_val=%0h", i, kind, sel, busy, max_val);
        return;
      end
    end
    chk("end_done", {31'd0, done}, 32'd1);
    chk("end_sel", {28'd0, sel}, 32'd0);
    chk("end_busy", {31'd0, busy}, 32'd0);
    prev_val = ev;
    prev_idx = ei;
    @(posedge clk); #1;
    chk("after_done", {31'd0, done}, 32'd0);
    chk("after_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    for (int k = 0; k < 10; k++) logits[k] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sel", {28'd0, sel}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_max_val", {8'd0, max_val}, 32'd0);
    chk("rst_max_idx", {28'd0, max_idx}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Descending first so max_val must hold its reset value during the scan.
    set_ramp(1'b0);
    run_scan(24'd10, 4'd1, 0, 0, 0);
    set_ramp(1'b1);
    run_scan(24'd10, 4'd10, 0, 0, 0);
    for (int k = 0; k < 10; k++) logits[k] = 24'h000005;
    run_scan(24'h000005, 4'd1, 0, 0, 0);
    logits[0] = -24'sd8;  logits[1] = -24'sd3;  logits[2] = -24'sd20;
    logits[3] = -24'sd5;  logits[4] = -24'sd9;  logits[5] = -24'sd4;
    logits[6] = -24'sd1;  logits[7] = -24'sd30; logits[8] = -24'sd7;
    logits[9] = -24'sd1;
    run_scan(24'hFFFFFF, 4'd7, 0, 0, 0);
    // Extremes of the signed range: most positive at 4, most negative first.
    for (int k = 0; k < 10; k++) logits[k] = 24'sd0;
    logits[0] = 24'h800000;
    logits[3] = 24'h7FFFFF;
    run_scan(24'h7FFFFF, 4'd4, 0, 0, 0);

    // start re-pulsed mid-scan is ignored.
    set_ramp(1'b1);
    run_scan(24'd10, 4'd10, 4, 0, 0);

    // start held high: back-to-back scans, done every 11 cycles.
    logits[2] = 24'd50;
    for (int n = 0; n < 3; n++) sb_q.push_back({24'd50, 4'd3});
    start = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 33; c++) begin
      chk("held_done", {31'd0, done}, (c % 11 == 0) ? 32'd1 : 32'd0);
      if (c % 11 != 0) chk("held_sel", {28'd0, sel}, c % 11);
      if (c == 32) start = 1'b0;
      if (c < 33) begin
        @(posedge clk); #1;
      end
    end
    prev_val = 24'd50;
    prev_idx = 4'd3;
    @(posedge clk); #1;
    chk("held_idle", {31'd0, busy}, 32'd0);

    // Reset mid-scan clears the previous result and suppresses done.
    set_ramp(1'b1);
    run_scan(24'd0, 4'd0, 0, 5, 1);
    repeat (12) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'd0, busy}, 32'd0);

`ifdef MAX_SCAN_ABORT_EN
    run_scan(24'd10, 4'd10, 0, 0, 0);
    run_scan(24'd0, 4'd0, 0, 6, 2);
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    chk("abort_blocks_start", {31'd0, busy}, 32'd0);
    chk("abort_keep_val", {8'd0, max_val}, 32'd10);
    chk("abort_keep_idx", {28'd0, max_idx}, 32'd10);
    repeat (12) @(posedge clk);
    #1;
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/max_scan_ctrl.md
# max_scan_ctrl

Sequencer and running-max stage that sits directly around the 10-to-1 softmax input multiplexer. It drives the mux select serially through the ten logits (sel = 1..10, 0 = idle/parked), consumes the selected value on the same cycle, and reports the maximum logit and its position. The result feeds the subtract-max / exponent stage so the softmax is numerically stable.

## Interface
- DATA_WIDTH, 24, logit width, signed two's complement; must match the mux data width.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin a scan; sampled only in IDLE.
- mux_out  input  DATA_WIDTH  selected logit from the mux; combinational from sel.
- sel  output  4  mux select, registered; 0 when idle, 1..10 during scan.
- busy  output  1  high while in SCAN.
- done  output  1  one-cycle pulse when max_val/max_idx update.
- max_val  output  DATA_WIDTH  maximum logit of the last completed scan.
- max_idx  output  4  position of max_val using sel encoding, 1..10.
- abort  input  1  present only with MAX_SCAN_ABORT_EN; cancels a scan.

## Operation
- States: IDLE, SCAN.
- IDLE: sel = 0, busy = 0. If start = 1, set sel <= 1 and go to SCAN.
- SCAN: each cycle, compare mux_out against the running max as signed DATA_WIDTH values.
  - When sel == 1, load run_max <= mux_out and run_idx <= 1 unconditionally.
  - Otherwise, update only if mux_out > run_max (strict). Ties keep the lowest index.
  - If sel < 10: sel <= sel + 1.
  - If sel == 10: max_val <= final max including the current mux_out; max_idx likewise; done <= 1; sel <= 0; go to IDLE.
- start while in SCAN is ignored; it is neither queued nor restarts the scan.
- max_val and max_idx change only on the done cycle. They hold the previous result during a scan.
- Running registers (run_max, run_idx) are internal. Their values outside SCAN are don't-care.
- No wider arithmetic is needed: the comparison is a pure signed compare, with no overflow.
- Reset values: sel = 0, busy = 0, done = 0, max_val = 0, max_idx = 0, state = IDLE.

## Timing
- Cycle T: start = 1 sampled in IDLE.
- T+1 … T+10: sel = 1 … 10, busy = 1. mux_out is compared in the same cycle its sel is presented.
- T+11: done = 1, busy = 0, sel = 0, max_val/max_idx valid. Valid until the next done.
- Latency from start to done is 11 cycles.
- start at T+11 is accepted (state is IDLE), giving back-to-back scans every 11 cycles.
- rst asserted mid-scan: next cycle all outputs are at reset values, state is IDLE, no done pulse, previous result is cleared.
- rst and start in the same cycle: rst wins.

## Configuration
- MAX_SCAN_ABORT_EN defined:
  - adds the abort input.
  - abort = 1 in SCAN: next cycle state = IDLE, sel = 0, busy = 0, no done pulse, max_val/max_idx keep the previous completed result.
  - abort in IDLE has no effect. abort together with start in IDLE: abort wins and no scan starts.
  - abort on the sel == 10 cycle: abort wins, no done pulse.
  - rst has priority over abort.
- MAX_SCAN_ABORT_EN undefined: no abort port; a scan always runs to completion unless rst is asserted.

## Test plan
- Ascending logits 1,2,…,10, start pulse → sel steps 1..10 on cycles T+1..T+10; done at T+11; max_val = 10, max_idx = 10.
- Descending logits 10..1 → max_val = 10, max_idx = 1; max_val unchanged (reset value 0) until the done cycle.
- All logits = 0x000005 → max_idx = 1 (tie keeps lowest). Mixed signed set {-8, -3, -1 at position 7, -20, …} → max_val = 0xFFFFFF, max_idx = 7.
- start re-pulsed at T+4 → ignored; single done at T+11. start held high continuously → done at T+11, T+22, T+33.
- rst at T+5 → sel = 0, busy = 0, max_val = 0, max_idx = 0 at T+6; no done pulse.
- With MAX_SCAN_ABORT_EN: complete one scan (max 10 at idx 10), then abort at T+6 of the second scan → sel = 0 at T+7, no done, max_val = 10 and max_idx = 10 retained.
